button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter REPEAT_DELAY, default 0, cycles from accepted press to first auto-repeat pulse; 0 disables auto-repeat.
REQ-003 Parameter REPEAT_PERIOD, default 8, cycles between successive auto-repeat pulses; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 button_raw  input  1  unsynchronized, bouncing mechanical button; 1 = pressed.
REQ-007 btn_level  output  1  debounced button level; drives button_inp of the downstream LED event stage.
REQ-008 btn_press  output  1  one-cycle pulse on accepted press.
REQ-009 btn_release  output  1  one-cycle pulse on accepted release.
REQ-010 btn_repeat  output  1  one-cycle auto-repeat pulse while held.
REQ-011 btn_event  output  1  OR of btn_press and btn_repeat.

Function
REQ-012 button_raw SHALL pass through a 2-flop synchronizer; sync_q is the second-flop output; no other logic SHALL sample button_raw.
REQ-013 Control SHALL be a 4-state FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 IDLE: sync_q=1 -> PRESS_WAIT with debounce counter loaded to 1; else stay.
REQ-015 PRESS_WAIT: sync_q=0 -> IDLE, counter cleared; sync_q=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; else counter+1.
REQ-016 PRESSED: sync_q=0 -> RELEASE_WAIT with counter loaded to 1; else stay.
REQ-017 RELEASE_WAIT: sync_q=1 -> PRESSED, counter cleared, no pulse, repeat timing not restarted; sync_q=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-018 Accepted press therefore requires DEBOUNCE_CYCLES consecutive sync_q=1 samples; latency from stable button_raw rise to btn_press = DEBOUNCE_CYCLES+2 cycles; release symmetric.
REQ-019 btn_level SHALL be registered, 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
REQ-020 btn_press SHALL be high exactly the cycle btn_level first reads 1; btn_release exactly the cycle btn_level first reads 0.
REQ-021 Repeat counter SHALL clear on PRESS_WAIT->PRESSED and count each cycle in PRESSED or RELEASE_WAIT.
REQ-022 With REPEAT_DELAY>0, btn_repeat SHALL pulse when the count reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles while held; the counter SHALL reload rather than wrap, so no pulse is lost or duplicated on long holds.
REQ-023 btn_repeat SHALL never coincide with btn_press or btn_release; in the release cycle the repeat pulse is suppressed.
REQ-024 Counters SHALL be sized to $clog2 of the largest parameter plus 1 and SHALL saturate, never wrap.
REQ-025 All outputs SHALL be registered; no combinational path from button_raw to any output.

Reset
REQ-026 rst=0 SHALL immediately force FSM=IDLE, synchronizer flops=0, all counters=0, all outputs=0, regardless of clk.
REQ-027 Reset deassertion SHALL be synchronized internally (2-flop release); first state update SHALL occur on the second rising clk after rst rises.
REQ-028 Reset mid-press SHALL produce no btn_release pulse; a button held through reset SHALL be re-qualified as a new press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 Clean press: button_raw 0->1 held -> btn_level=1 and one btn_press pulse at cycle 6 after the edge; btn_event pulses the same cycle.
REQ-030 Bounce: button_raw toggles 1,0,1,1,0 per cycle then stays 0 -> btn_level stays 0, no pulses.
REQ-031 Release glitch: held, one 1-cycle low on button_raw -> btn_level stays 1, no btn_release, no extra btn_press.
REQ-032 Auto-repeat: hold 25 cycles after btn_press -> btn_repeat at +10, +13, +16, +19, +22; btn_event matches press+repeats.
REQ-033 Reset mid-hold: rst=0 while btn_level=1 -> all outputs 0 asynchronously; no btn_release; after rst=1 with button held -> new btn_press after 4 stable samples.
REQ-034 Chain test: connect btn_level to event-stage button_inp -> LED pair alternates only while debounced level is 1.

Source files
------------

// File: rtl/button_conditioner.sv
// Debounces a bouncing button and derives press/release/auto-repeat pulses.
// Latency DEBOUNCE_CYCLES+2 clocks from a stable raw edge; no backpressure, every output is registered.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat,
    output logic btn_event
);

    localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RPT_DLY = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RPT_PER = CW'(REPEAT_PERIOD);
    localparam logic          RPT_ON  = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Reset release flop: logic below only advances once it has captured a 1,
    // so the first update lands on the second clock after rst rises.
    logic rst_rel_q;
    logic rst_rel_d;

    logic          meta_q,     meta_d;
    logic          sync_q,     sync_d;
    state_t        state_q,    state_d;
    logic [CW-1:0] db_cnt_q,   db_cnt_d;
    logic [CW-1:0] rpt_cnt_q,  rpt_cnt_d;
    logic          rpt_per_q,  rpt_per_d;
    logic          level_q,    level_d;
    logic          press_q,    press_d;
    logic          release_q,  release_d;
    logic          repeat_q,   repeat_d;
    logic          event_q,    event_d;

    logic [CW-1:0] db_inc;
    logic [CW-1:0] rpt_inc;
    logic [CW-1:0] rpt_target;

    always_comb begin
        rst_rel_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_rel_q <= 1'b0;
        end else begin
            rst_rel_q <= rst_rel_d;
        end
    end

    always_comb begin
        meta_d     = meta_q;
        sync_d     = sync_q;
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        rpt_cnt_d  = rpt_cnt_q;
        rpt_per_d  = rpt_per_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        repeat_d   = 1'b0;
        event_d    = 1'b0;
        db_inc     = (&db_cnt_q)  ? db_cnt_q  : db_cnt_q  + ONE;
        rpt_inc    = (&rpt_cnt_q) ? rpt_cnt_q : rpt_cnt_q + ONE;
        rpt_target = rpt_per_q ? RPT_PER : RPT_DLY;

        if (rst_rel_q) begin
            meta_d = button_raw;
            sync_d = meta_q;

            case (state_q)
                IDLE: begin
                    if (sync_q) begin
                        state_d  = PRESS_WAIT;
                        db_cnt_d = ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_q) begin
                        state_d  = IDLE;
                        db_cnt_d = '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d  = PRESSED;
                        db_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end
                PRESSED: begin
                    if (!sync_q) begin
                        state_d  = RELEASE_WAIT;
                        db_cnt_d = ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_q) begin
                        state_d  = PRESSED;
                        db_cnt_d = '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d  = IDLE;
                        db_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end
            endcase

            level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
            press_d   = level_d & ~level_q;
            release_d = ~level_d & level_q;

            // Repeat timing runs only while the debounced level stays high;
            // a bounce back from RELEASE_WAIT keeps the running count.
            if (press_d) begin
                rpt_cnt_d = '0;
                rpt_per_d = 1'b0;
            end else if (level_q && level_d) begin
                if (RPT_ON && (rpt_inc == rpt_target)) begin
                    repeat_d  = 1'b1;
                    rpt_cnt_d = '0;
                    rpt_per_d = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_inc;
                end
            end else if (!level_d) begin
                rpt_cnt_d = '0;
                rpt_per_d = 1'b0;
            end

            event_d = press_d | repeat_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            state_q   <= IDLE;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
            rpt_per_q <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            rpt_per_q <= rpt_per_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            event_q   <= event_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;
    assign btn_event   = event_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing input,
// every cycle compared against a run-length / elapsed-time reference model.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button_raw = 1'b0;
    logic btn_level, btn_press, btn_release, btn_repeat, btn_event;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button_raw (button_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat),
        .btn_event  (btn_event)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the level flips after DB consecutive synchronized samples
    // that disagree with it; repeats fall at press+RD+k*RP while the level holds.
    logic    m_rel, m_meta, m_sync, m_level;
    logic    m_press, m_release, m_repeat, m_event;
    logic    m_samp, m_new;
    int      m_run;
    longint  m_cyc, m_tp, m_h;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rel = 0; m_meta = 0; m_sync = 0; m_level = 0;
            m_press = 0; m_release = 0; m_repeat = 0; m_event = 0;
            m_run = 0; m_cyc = 0; m_tp = 0;
        end else begin
            if (m_rel) begin
                m_samp = m_sync;
                m_sync = m_meta;
                m_meta = button_raw;
                m_cyc++;
                if (m_samp != m_level) m_run++;
                else m_run = 0;
                m_new = m_level;
                if (m_run == DB) begin
                    m_new = ~m_level;
                    m_run = 0;
                end
                m_press   = m_new & ~m_level;
                m_release = ~m_new & m_level;
                if (m_press) m_tp = m_cyc;
                m_h = m_cyc - m_tp;
                m_repeat = (RD > 0) && m_level && m_new && (m_h >= RD) && (((m_h - RD) % RP) == 0);
                m_event  = m_press | m_repeat;
                m_level  = m_new;
            end
            m_rel = 1;
        end
    end

    always @(negedge clk) begin
        chk("level",   btn_level,   m_level);
        chk("press",   btn_press,   m_press);
        chk("release", btn_release, m_release);
        chk("repeat",  btn_repeat,  m_repeat);
        chk("event",   btn_event,   m_event);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] rep_seen, ev_seen;
    logic [4:0]  pat;
    int          cnt_a, cnt_b, cnt_c, at;
    logic        lvl_min;

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_level", btn_level, 0);
        chk("rst_pulses", {btn_press, btn_release, btn_repeat, btn_event}, 0);
        rst = 1'b1;
        repeat (6) tick();

        // Clean press
        button_raw = 1'b1;
        repeat (5) tick();
        chk("press_early_level", btn_level, 0);
        tick();
        chk("press_lat_level", btn_level, 1);
        chk("press_lat_pulse", btn_press, 1);
        chk("press_lat_event", btn_event, 1);

        // Auto-repeat offsets relative to the press
        rep_seen = '0; ev_seen = '0; cnt_a = 0;
        for (int t = 1; t <= 24; t++) begin
            tick();
            rep_seen[t] = btn_repeat;
            ev_seen[t]  = btn_event;
            cnt_a += int'(btn_press);
        end
        chk("repeat_offsets", rep_seen, 32'h0049_2400);
        chk("event_offsets",  ev_seen,  32'h0049_2400);
        chk("hold_extra_press", cnt_a, 0);

        // One-cycle release glitch
        button_raw = 1'b0;
        tick();
        button_raw = 1'b1;
        lvl_min = 1'b1; cnt_a = 0; cnt_b = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            lvl_min &= btn_level;
            cnt_a += int'(btn_release);
            cnt_b += int'(btn_press);
        end
        chk("glitch_level", lvl_min, 1);
        chk("glitch_release", cnt_a, 0);
        chk("glitch_press", cnt_b, 0);

        // Clean release
        button_raw = 1'b0;
        at = -1; cnt_c = 0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (btn_release && at < 0) at = t;
            if (btn_release && btn_repeat) cnt_c++;
        end
        chk("release_latency", at, 6);
        chk("release_repeat_overlap", cnt_c, 0);
        repeat (4) tick();

        // Bounce: 1,0,1,1,0 then low
        pat = 5'b01101;
        cnt_a = 0;
        for (int i = 0; i < 5; i++) begin
            button_raw = pat[i];
            tick();
            cnt_a += int'(btn_level) + int'(btn_press) + int'(btn_release) + int'(btn_repeat);
        end
        button_raw = 1'b0;
        for (int t = 0; t < 15; t++) begin
            tick();
            cnt_a += int'(btn_level) + int'(btn_press) + int'(btn_release) + int'(btn_repeat);
        end
        chk("bounce_quiet", cnt_a, 0);

        // Reset while held
        button_raw = 1'b1;
        repeat (8) tick();
        chk("pre_reset_level", btn_level, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_outputs", {btn_level, btn_press, btn_release, btn_repeat, btn_event}, 0);
        cnt_a = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            cnt_a += int'(btn_release);
        end
        chk("reset_no_release", cnt_a, 0);
        rst = 1'b1;
        at = -1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (btn_press && at < 0) at = t;
        end
        chk("requalify_press", at, 7);

        // Random bouncing, holds and occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            int mode, len;
            mode = int'($urandom_range(0, 9));
            if (mode < 6) begin
                button_raw = $urandom_range(0, 1) == 1;
                len = int'($urandom_range(1, 30));
                repeat (len) tick();
            end else if (mode < 9) begin
                len = int'($urandom_range(1, 8));
                for (int i = 0; i < len; i++) begin
                    button_raw = $urandom_range(0, 1) == 1;
                    tick();
                end
            end else begin
                rst = 1'b0;
                len = int'($urandom_range(1, 3));
                repeat (len) tick();
                rst = 1'b1;
            end
        end
        button_raw = 1'b0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
